vga_timing_gen: RTL and testbench

//  Upstream VGA timing stage for the pixel renderers (base image ROM + palette path).
//  - Generates 640x480@60 raster coordinates DrawX/DrawY, the active-video flag `blank` and the monitor syncs.
//  - Renderers add SYNC_DELAY cycles of ROM/output-register latency.
//  - hs/vs are therefore re-timed through a delay line, so they reach the DAC aligned with the renderers' registered RGB.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_timing_if.sv | 28 ++
 rtl/sync_delay_line.sv | 37 +++
 rtl/vga_timing_gen.sv | 89 ++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate type.
// Renderers import this for the active-area decode.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Idle value of the {hs, vs, blank} bundle
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  function automatic logic in_window(
    input coord_t c,
    input coord_t lo,
    input coord_t hi
  );
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle from the timing generator to the renderers/DAC.
// Free-running, no handshake.
interface vga_timing_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   blank_d;
  logic   hs;
  logic   vs;
  logic   sync;
  logic   line_start;
  logic   frame_start;

  modport master (
    output DrawX, DrawY, blank, blank_d,
    output hs, vs, sync,
    output line_start, frame_start
  );

  modport slave (
    input DrawX, DrawY, blank, blank_d,
    input hs, vs, sync,
    input line_start, frame_start
  );

endinterface

// File: rtl/sync_delay_line.sv
// Async-reset shift register used to re-time sync signals.
// DEPTH=0 is a plain wire-through.
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++)
            sr[i] <= RESET_VAL;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++)
            sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, active/sync decode and re-timed syncs.
// Flags are decoded from next-state counts so they align with DrawX/DrawY.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_DELAY = 2
) (
  input  logic  vga_clk,
  input  logic  reset_n,
  vga_timing_if.master vga
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t HA     = coord_t'(H_ACTIVE);
  localparam coord_t VA     = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t     h_q, v_q;
  coord_t     h_nxt, v_nxt;
  logic       h_wrap;
  logic       blank_q, ls_q, fs_q;
  logic       hs_raw, vs_raw;
  logic [2:0] dly_q;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_nxt  = h_wrap ? '0 : h_q + coord_t'(1);
    v_nxt  = v_q;
    if (h_wrap)
      v_nxt = (v_q == V_LAST) ? '0 : v_q + coord_t'(1);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q     <= '0;
      v_q     <= '0;
      blank_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      hs_raw  <= 1'b1;
      vs_raw  <= 1'b1;
    end else begin
      h_q     <= h_nxt;
      v_q     <= v_nxt;
      blank_q <= (h_nxt < HA) && (v_nxt < VA);
      ls_q    <= (h_nxt == '0);
      fs_q    <= (h_nxt == '0) && (v_nxt == '0);
      hs_raw  <= !in_window(h_nxt, HS_LO, HS_HI);
      vs_raw  <= !in_window(v_nxt, VS_LO, VS_HI);
    end
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d     ({hs_raw, vs_raw, blank_q}),
    .q     (dly_q)
  );

  assign vga.DrawX       = h_q;
  assign vga.DrawY       = v_q;
  assign vga.blank       = blank_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.hs          = dly_q[2];
  assign vga.vs          = dly_q[1];
  assign vga.blank_d     = dly_q[0];
  assign vga.sync        = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: four generators (640x480 with delay 2/0/5, small raster delay 2)
// checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    int d;
  } cfg_t;

  typedef struct {
    logic [31:0] x, y;
    logic [31:0] b, bd, hs, vs, ls, fs, sy;
  } obs_t;

  logic vga_clk = 1'b0;
  logic reset_n;
  int   n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   checking = 0;
  bit   first_run = 1;
  int   hs0_low = 0;
  int   first_hs [3] = '{-1, -1, -1};
  int   s_fs = 0, s_vs = 0, s_bl = 0;
  obs_t got [4];

  vga_timing_if if_d2 ();
  vga_timing_if if_d0 ();
  vga_timing_if if_d5 ();
  vga_timing_if if_s2 ();

  vga_timing_gen #(.SYNC_DELAY(2)) u_d2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d2));
  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d0));
  vga_timing_gen #(.SYNC_DELAY(5)) u_d5 (
    .vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d5));
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(2)
  ) u_s2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .vga(if_s2));

  always #5 vga_clk = ~vga_clk;

  // n = rising edges since the last reset release
  always @(posedge vga_clk) n = reset_n ? n + 1 : 0;
  always @(negedge reset_n) n = 0;

  function automatic cfg_t cfg_of(input int i);
    cfg_t c;
    if (i == 3) c = '{16, 4, 6, 4, 12, 2, 2, 3, 2};
    else c = '{640, 16, 96, 48, 480, 10, 2, 33,
               (i == 0) ? 2 : (i == 1) ? 0 : 5};
    return c;
  endfunction

  function automatic int ht_of(input cfg_t c);
    return c.ha + c.hfp + c.hsw + c.hbp;
  endfunction

  function automatic int vt_of(input cfg_t c);
    return c.va + c.vfp + c.vsw + c.vbp;
  endfunction

  function automatic bit hs_at(input cfg_t c, input int m);
    int x;
    if (m <= 0) return 1'b1;
    x = m % ht_of(c);
    return !(x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw);
  endfunction

  function automatic bit vs_at(input cfg_t c, input int m);
    int y;
    if (m <= 0) return 1'b1;
    y = (m / ht_of(c)) % vt_of(c);
    return !(y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw);
  endfunction

  function automatic bit act_at(input cfg_t c, input int m);
    int x, y;
    if (m <= 0) return 1'b0;
    x = m % ht_of(c);
    y = (m / ht_of(c)) % vt_of(c);
    return (x < c.ha) && (y < c.va);
  endfunction

  function automatic obs_t model(input int i, input int m);
    cfg_t c;
    obs_t e;
    int   x, y;
    c = cfg_of(i);
    x = m % ht_of(c);
    y = (m / ht_of(c)) % vt_of(c);
    e.x  = 32'(x);
    e.y  = 32'(y);
    e.b  = 32'(act_at(c, m));
    e.bd = 32'(act_at(c, m - c.d));
    e.hs = 32'(hs_at(c, m - c.d));
    e.vs = 32'(vs_at(c, m - c.d));
    e.ls = 32'(m > 0 && x == 0);
    e.fs = 32'(m > 0 && x == 0 && y == 0);
    e.sy = 32'd0;
    return e;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s inst=%0d n=%0d got=%0h want=%0h",
               nm, i, n, g, e);
    end
  endtask

  task automatic sample();
    got[0] = '{32'(if_d2.DrawX), 32'(if_d2.DrawY), 32'(if_d2.blank),
               32'(if_d2.blank_d), 32'(if_d2.hs), 32'(if_d2.vs),
               32'(if_d2.line_start), 32'(if_d2.frame_start),
               32'(if_d2.sync)};
    got[1] = '{32'(if_d0.DrawX), 32'(if_d0.DrawY), 32'(if_d0.blank),
               32'(if_d0.blank_d), 32'(if_d0.hs), 32'(if_d0.vs),
               32'(if_d0.line_start), 32'(if_d0.frame_start),
               32'(if_d0.sync)};
    got[2] = '{32'(if_d5.DrawX), 32'(if_d5.DrawY), 32'(if_d5.blank),
               32'(if_d5.blank_d), 32'(if_d5.hs), 32'(if_d5.vs),
               32'(if_d5.line_start), 32'(if_d5.frame_start),
               32'(if_d5.sync)};
    got[3] = '{32'(if_s2.DrawX), 32'(if_s2.DrawY), 32'(if_s2.blank),
               32'(if_s2.blank_d), 32'(if_s2.hs), 32'(if_s2.vs),
               32'(if_s2.line_start), 32'(if_s2.frame_start),
               32'(if_s2.sync)};
  endtask

  task automatic chk_reset_state(input int i);
    chk("rst_x", i, got[i].x, 0);
    chk("rst_y", i, got[i].y, 0);
    chk("rst_blank", i, got[i].b, 0);
    chk("rst_blank_d", i, got[i].bd, 0);
    chk("rst_hs", i, got[i].hs, 1);
    chk("rst_vs", i, got[i].vs, 1);
  endtask

  always @(negedge vga_clk) begin
    if (checking) begin
      obs_t e;
      sample();
      for (int i = 0; i < 4; i++) begin
        e = model(i, n);
        chk("DrawX", i, got[i].x, e.x);
        chk("DrawY", i, got[i].y, e.y);
        chk("blank", i, got[i].b, e.b);
        chk("blank_d", i, got[i].bd, e.bd);
        chk("hs", i, got[i].hs, e.hs);
        chk("vs", i, got[i].vs, e.vs);
        chk("line_start", i, got[i].ls, e.ls);
        chk("frame_start", i, got[i].fs, e.fs);
        chk("sync", i, got[i].sy, e.sy);
      end
      // Hand-derived expectations that pin the model itself
      if (first_run && reset_n && n >= 1) begin
        if (n <= 800) begin
          if (got[1].hs == 0) hs0_low++;
          for (int i = 0; i < 3; i++)
            if (first_hs[i] < 0 && got[i].hs == 0)
              first_hs[i] = int'(got[i].x);
        end
        if (n <= 570) begin
          if (got[3].fs == 1) s_fs++;
          if (got[3].vs == 0) s_vs++;
          if (got[3].b == 1) s_bl++;
        end
        if (n == 1) begin
          chk("lit_first_x", 0, got[0].x, 1);
          chk("lit_first_blank", 0, got[0].b, 1);
        end
        if (n == 570) begin
          chk("lit_s_wrap_x", 3, got[3].x, 0);
          chk("lit_s_wrap_y", 3, got[3].y, 0);
          chk("lit_s_fs_cnt", 3, s_fs, 1);
          chk("lit_s_vs_low", 3, s_vs, 60);
          chk("lit_s_active", 3, s_bl, 192);
        end
        if (n == 800) begin
          chk("lit_wrap_x", 0, got[0].x, 0);
          chk("lit_wrap_y", 0, got[0].y, 1);
          chk("lit_hs_low_cnt", 1, hs0_low, 96);
          chk("lit_hs_start_d2", 0, first_hs[0], 658);
          chk("lit_hs_start_d0", 1, first_hs[1], 656);
          chk("lit_hs_start_d5", 2, first_hs[2], 661);
        end
      end
    end
  end

  initial begin
    bit found;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 checking = 1;
    repeat ($urandom_range(5, 8)) @(negedge vga_clk);
    #2 reset_n = 1'b1;

    found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge vga_clk);
      if (if_d2.DrawX == 10'd300 && if_d2.DrawY == 10'd2) found = 1;
    end
    chk("reach_300_2", 0, 32'(found), 1);

    // Async reset between edges: outputs must drop before the next edge
    #2 first_run = 0;
    reset_n = 1'b0;
    #1 sample();
    chk_reset_state(0);
    chk_reset_state(3);
    repeat ($urandom_range(1, 4)) @(negedge vga_clk);
    #2 reset_n = 1'b1;
    repeat ($urandom_range(1500, 2500)) @(negedge vga_clk);

    // Random short pulses, some within a single low phase
    repeat (3) begin
      repeat ($urandom_range(20, 400)) @(negedge vga_clk);
      #($urandom_range(1, 2)) reset_n = 1'b0;
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) @(negedge vga_clk);
      #1 reset_n = 1'b1;
      repeat ($urandom_range(50, 300)) @(negedge vga_clk);
    end

    @(negedge vga_clk);
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
